// File: rtl/wb_dbg_pkg.sv
// Shared constants and types for the byte-stream to Wishbone debug bridge.
package wb_dbg_pkg;

  // Host command opcodes
  localparam logic [7:0] OP_WR = 8'h57;  // 'W'
  localparam logic [7:0] OP_RD = 8'h52;  // 'R'

  // Response bytes returned to the host
  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'
  localparam logic [7:0] RSP_BAD = 8'h3F;  // '?'

  // Only classic single cycles are issued
  localparam logic [2:0] CTI_CLASSIC = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RETRY,
    S_RESP,
    S_RDATA
  } state_t;

  function automatic logic is_known_op(input logic [7:0] op);
    return (op == OP_WR) || (op == OP_RD);
  endfunction

endpackage

// File: rtl/wb_debug_master.sv
// Wishbone initiator driven by host command bytes; replies as a byte stream.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | waiting for an opcode byte
//  S_ADDR  | collecting 4 address bytes, MSB first
//  S_DATA  | collecting 4 write-data bytes, MSB first (write only)
//  S_BUS   | CYC/STB asserted, waiting for ACK/ERR/RTY or timeout
//  S_RETRY | one idle cycle with CYC/STB low after RTY, then re-issue
//  S_RESP  | presenting the status byte ('K', 'E' or '?')
//  S_RDATA | presenting 4 read-data bytes, MSB first (read 'K' only)
module wb_debug_master
  import wb_dbg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        ACK,
  input  logic        ERR,
  input  logic        RTY,
  output logic        STB,
  output logic        CYC,
  output logic [31:0] ADR,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic [2:0]  CTI_O,
  output logic        WE,
  output logic        busy
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  // Loaded one short so the terminal count of zero lands on the last allowed cycle
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q;
  logic [31:0]       addr_q;
  logic [31:0]       data_q;
  logic [31:0]       rdata_q;
  logic              is_write_q;
  logic [7:0]        rsp_q;
  logic [RTY_W-1:0]  retry_q;
  logic [TMO_W-1:0]  tmo_q;

  logic rx_fire;
  logic tx_fire;

  assign rx_fire = rx_valid & rx_ready;
  assign tx_fire = tx_valid & tx_ready;

  assign ADR   = {addr_q[31:2], 2'b00};
  assign DAT_O = data_q;
  assign CTI_O = CTI_CLASSIC;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_fire) state_d = is_known_op(rx_data) ? S_ADDR : S_RESP;
      end
      S_ADDR: begin
        if (rx_fire && cnt_q == 2'd3) state_d = is_write_q ? S_DATA : S_BUS;
      end
      S_DATA: begin
        if (rx_fire && cnt_q == 2'd3) state_d = S_BUS;
      end
      S_BUS: begin
        if (ERR || ACK)         state_d = S_RESP;
        else if (RTY)           state_d = (retry_q == RTY_MAX) ? S_RESP : S_RETRY;
        else if (tmo_q == '0)   state_d = S_RESP;
      end
      S_RETRY: state_d = S_BUS;
      S_RESP: begin
        if (tx_fire) state_d = (rsp_q == RSP_OK && !is_write_q) ? S_RDATA : S_IDLE;
      end
      S_RDATA: begin
        if (tx_fire && cnt_q == 2'd3) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and bus outputs decoded from the current state
  always_comb begin
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    STB      = 1'b0;
    CYC      = 1'b0;
    WE       = 1'b0;
    busy     = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE, S_ADDR, S_DATA: rx_ready = 1'b1;
      S_BUS: begin
        STB = 1'b1;
        CYC = 1'b1;
        WE  = is_write_q;
      end
      S_RESP: begin
        tx_valid = 1'b1;
        tx_data  = rsp_q;
      end
      S_RDATA: begin
        tx_valid = 1'b1;
        tx_data  = rdata_q[31:24];
      end
      default: ;
    endcase
  end

  // Datapath: shift registers, shared byte counter, retry and timeout counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 2'd0;
      addr_q     <= 32'h0;
      data_q     <= 32'h0;
      rdata_q    <= 32'h0;
      is_write_q <= 1'b0;
      rsp_q      <= 8'h00;
      retry_q    <= '0;
      tmo_q      <= TMO_LOAD;
    end else begin
      // Timer reloads whenever the bus is not strobed, so every (re)issue starts fresh
      if (state_q != S_BUS) tmo_q <= TMO_LOAD;
      else                  tmo_q <= tmo_q - 1'b1;

      unique case (state_q)
        S_IDLE: begin
          cnt_q   <= 2'd0;
          retry_q <= '0;
          if (rx_fire) begin
            is_write_q <= (rx_data == OP_WR);
            if (!is_known_op(rx_data)) rsp_q <= RSP_BAD;
          end
        end
        S_ADDR: begin
          if (rx_fire) begin
            addr_q <= {addr_q[23:0], rx_data};
            cnt_q  <= cnt_q + 2'd1;
          end
        end
        S_DATA: begin
          if (rx_fire) begin
            data_q <= {data_q[23:0], rx_data};
            cnt_q  <= cnt_q + 2'd1;
          end
        end
        S_BUS: begin
          if (ERR) begin
            rsp_q <= RSP_ERR;
          end else if (ACK) begin
            rsp_q <= RSP_OK;
            if (!is_write_q) rdata_q <= DAT_I;
          end else if (RTY) begin
            if (retry_q == RTY_MAX) rsp_q <= RSP_ERR;
            else                    retry_q <= retry_q + 1'b1;
          end else if (tmo_q == '0) begin
            rsp_q <= RSP_ERR;
          end
        end
        S_RDATA: begin
          if (tx_fire) begin
            rdata_q <= {rdata_q[23:0], 8'h00};
            cnt_q   <= cnt_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
